fp_sqr_arbiter: RTL and testbench
=================================

Name: fp_sqr_arbiter

Overview:
Shares one fp_sqr square-root unit among NREQ requesters. Requesters are served in round-robin order.
- Per granted request: captures the operand and rounding mode, drives them stably into the unit, waits for its done, then returns result plus flags tagged with the requester id.
- Sits between the FPU issue logic and the fp_sqr instance. Holds the response until it is accepted.

Parameters:
W, 32, operand/result width
NREQ, 4, number of requesters (2..8)
IDW, 2, requester id width, equal to clog2(NREQ)
MIN_LAT, 3, cycles after issue during which sqr_done is ignored (masks a stale done)
TIMEOUT, 64, maximum WAIT cycles before the op is aborted

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  NREQ  per-requester request
req_data  in  W*NREQ  operands; requester i at bits [W*i +: W]
req_round  in  3*NREQ  rounding modes (RNe/RZ/RU/RD/RNa encodings)
req_ready  out  NREQ  one-hot, one-cycle grant/accept pulse
sqr_in1  out  W  operand to fp_sqr
sqr_round_m  out  3  rounding mode to fp_sqr
sqr_act  out  1  high while the unit owns an operation
sqr_out  in  W  fp_sqr result
sqr_flags  in  5  {inv,ov,un,inexact,spare}; spare is ignored
sqr_done  in  1  fp_sqr done
rsp_valid  out  1  response valid
rsp_ready  in  1  consumer accepts response
rsp_id  out  IDW  requester index
rsp_data  out  W  result
rsp_flags  out  5  {inv,ov,un,inexact,timeout}
busy  out  1  state != IDLE

Behaviour:
- Reset (rst high at a clk edge): state=IDLE, rr_ptr=NREQ-1, all outputs 0, latched operand/mode/id cleared, counters 0. Reset has priority over every event, including mid-WAIT and mid-RESP; any in-flight op is dropped with no response.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE
  - If any req_valid: pick the first set bit scanning from rr_ptr+1 upward, wrapping modulo NREQ.
  - In the same cycle: assert req_ready[g] combinationally; latch operand, mode and id=g.
  - rr_ptr<=g; next state ISSUE.
  - If no req_valid: stay in IDLE, req_ready=0.
- ISSUE (1 cycle)
  - sqr_in1/sqr_round_m driven from latches and held constant through WAIT.
  - sqr_act=1; wait counter cnt<=0; next state WAIT.
- WAIT
  - sqr_act=1; cnt increments each cycle.
  - sqr_done is ignored while cnt<MIN_LAT.
  - When cnt>=MIN_LAT and sqr_done=1: latch rsp_data=sqr_out and rsp_flags={sqr_flags[4:1],1'b0}; go to RESP.
  - If cnt reaches TIMEOUT-1 without a qualifying done: rsp_data=32'h7FC00000, rsp_flags=5'b10001 (inv+timeout); go to RESP.
  - Done and timeout in the same cycle: done wins.
- RESP
  - rsp_valid=1; sqr_act=0; rsp_data/flags/id stable until handshake.
  - On rsp_valid&rsp_ready: rsp_valid drops next cycle; next state IDLE.
  - No new grant is issued in the handshake cycle. Minimum grant-to-grant spacing is 4+MIN_LAT cycles.
- Fairness: a requester continuously asserting req_valid waits at most NREQ-1 other transactions.
- A req_valid deassertion before grant is legal; the request is simply not served.
- req_ready is never asserted outside IDLE.
- busy = (state != IDLE).
- Widths: cnt is clog2(TIMEOUT)+1 bits and saturates (no wrap). rr_ptr is IDW bits; the wrap uses an explicit compare with NREQ-1, not a power-of-two overflow.

Test Plan:
- Single request: req_valid=4'b0001, data 32'h40800000 (4.0), mode RNe; model asserts done 5 cycles after act. Required: req_ready[0] pulses once; rsp_valid with rsp_id=0, rsp_data=32'h40000000, rsp_flags=0.
- Round robin: all four valid continuously, rsp_ready=1. Required grant order 0,1,2,3,0; each response id matches its operand (1.0,4.0,9.0,16.0 -> 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000).
- Stale done: model holds done=1 from the previous op into cycles 0..2 of a new WAIT, then real done at cycle 6. Required: the result is taken at cycle 6, never earlier.
- Timeout: model never asserts done. Required: exactly TIMEOUT WAIT cycles, then rsp_data=32'h7FC00000, rsp_flags=5'b10001; FSM returns to IDLE after the handshake.
- Backpressure: rsp_ready=0 for 10 cycles with requests pending. Required: rsp_valid and rsp_data held constant, no req_ready pulses; the next grant occurs no earlier than the cycle after the handshake.
- Reset mid-WAIT: assert rst for 1 cycle during WAIT. Required: next cycle state IDLE, sqr_act=0, rsp_valid=0, rr_ptr=NREQ-1, so the next grant goes to requester 0 if valid.

Source files
------------

// File: rtl/fp_sqr_arbiter_if.sv
// fp_sqr_arbiter_if: requester, fp_sqr and response signals of the square-root arbiter
interface fp_sqr_arbiter_if #(
  parameter int W    = 32,
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [W*NREQ-1:0] req_data;
  logic [3*NREQ-1:0] req_round;
  logic [NREQ-1:0]   req_ready;
  logic [W-1:0]      sqr_in1;
  logic [2:0]        sqr_round_m;
  logic              sqr_act;
  logic [W-1:0]      sqr_out;
  logic [4:0]        sqr_flags;
  logic              sqr_done;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_data;
  logic [4:0]        rsp_flags;
  logic              busy;
  modport slave (
    input  req_valid, req_data, req_round, sqr_out, sqr_flags, sqr_done, rsp_ready,
    output req_ready, sqr_in1, sqr_round_m, sqr_act, rsp_valid, rsp_id, rsp_data, rsp_flags, busy
  );
  modport master (
    output req_valid, req_data, req_round, sqr_out, sqr_flags, sqr_done, rsp_ready,
    input  req_ready, sqr_in1, sqr_round_m, sqr_act, rsp_valid, rsp_id, rsp_data, rsp_flags, busy
  );
endinterface

// File: rtl/fp_sqr_arbiter.sv
// fp_sqr_arbiter: round-robin sharing of one fp_sqr unit among NREQ requesters
module fp_sqr_arbiter #(
  parameter int W       = 32,
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int MIN_LAT = 3,
  parameter int TIMEOUT = 64
) (
  input logic clk,
  input logic rst,
  fp_sqr_arbiter_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [W-1:0] QNAN = W'(32'h7FC00000);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t         state, state_n;
  logic [IDW-1:0] rr_ptr, gnt_id, idx, id_q;
  logic           gnt_any, done_ok, tmo;
  logic [W-1:0]   op_q, rsp_data_q;
  logic [2:0]     rm_q;
  logic [4:0]     rsp_flags_q;
  logic [CW-1:0]  cnt;
  // first valid requester after rr_ptr, wrapping explicitly at NREQ-1
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    idx     = rr_ptr;
    for (int k = 0; k < NREQ; k++) begin
      idx = (idx == IDW'(NREQ - 1)) ? '0 : idx + 1'b1;
      if (!gnt_any && bus.req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_id  = idx;
      end
    end
  end
  // a done seen in the first MIN_LAT wait cycles is a leftover from the previous op
  assign done_ok = bus.sqr_done && (cnt >= CW'(MIN_LAT));
  assign tmo     = cnt >= CW'(TIMEOUT - 1);
  // next state and the combinational grant pulse
  always_comb begin
    state_n       = state;
    bus.req_ready = '0;
    case (state)
      IDLE: if (gnt_any && !rst) begin
        bus.req_ready[gnt_id] = 1'b1;
        state_n               = ISSUE;
      end
      ISSUE: state_n = WAIT;
      WAIT:  state_n = (done_ok || tmo) ? RESP : WAIT;
      RESP:  state_n = bus.rsp_ready ? IDLE : RESP;
      default: state_n = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end
  // grant capture, wait counter and response latches
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr      <= IDW'(NREQ - 1);
      op_q        <= '0;
      rm_q        <= '0;
      id_q        <= '0;
      cnt         <= '0;
      rsp_data_q  <= '0;
      rsp_flags_q <= '0;
    end else begin
      if (state == IDLE && gnt_any) begin
        rr_ptr <= gnt_id;
        id_q   <= gnt_id;
        op_q   <= bus.req_data[W*gnt_id +: W];
        rm_q   <= bus.req_round[3*gnt_id +: 3];
      end
      cnt <= (state != WAIT) ? '0 : (&cnt) ? cnt : cnt + 1'b1;
      if (state == WAIT && done_ok) begin
        rsp_data_q  <= bus.sqr_out;
        rsp_flags_q <= bus.sqr_flags & 5'b11110;
      end else if (state == WAIT && tmo) begin
        rsp_data_q  <= QNAN;
        rsp_flags_q <= 5'b10001;
      end
    end
  end
  assign bus.sqr_in1     = op_q;
  assign bus.sqr_round_m = rm_q;
  assign bus.sqr_act     = (state == ISSUE) || (state == WAIT);
  assign bus.rsp_valid   = state == RESP;
  assign bus.rsp_id      = id_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_flags   = rsp_flags_q;
  assign bus.busy        = state != IDLE;
endmodule

// File: tb/tb_fp_sqr_arbiter.sv
// tb_fp_sqr_arbiter: directed checks of the fp_sqr round-robin arbiter against a behavioural fp_sqr
module tb_fp_sqr_arbiter;
  localparam int W = 32, NREQ = 4, IDW = 2, TIMEOUT = 64;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  fp_sqr_arbiter_if #(.W(W), .NREQ(NREQ), .IDW(IDW)) bus();
  fp_sqr_arbiter #(.W(W), .NREQ(NREQ), .IDW(IDW), .MIN_LAT(3), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  int total = 0, bad = 0, cyc = 0, act_cyc = 0, done_at = 5;
  bit stale = 1'b0, never = 1'b0, real_d;
  logic [4:0] flag_v = 5'b0;
  logic [3:0] g;
  int gc, gc_prev, lat, acts, extra, c0;
  logic [1:0] id;
  logic [31:0] d, in1;
  logic [4:0] f;
  logic [2:0] rm;
  bit chg, to;
  logic [31:0] ops [4] = '{32'h3F800000, 32'h40800000, 32'h41100000, 32'h41800000};
  logic [31:0] rts [4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
  function automatic logic [31:0] root(input logic [31:0] x);
    case (x)
      32'h3F800000: root = 32'h3F800000;
      32'h40800000: root = 32'h40000000;
      32'h41100000: root = 32'h40400000;
      32'h41800000: root = 32'h40800000;
      default:      root = 32'h0;
    endcase
  endfunction
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    act_cyc <= bus.sqr_act ? act_cyc + 1 : 0;
  end
  always_comb begin
    real_d        = bus.sqr_act && (act_cyc == done_at);
    bus.sqr_done  = bus.sqr_act && !never && (real_d || (stale && act_cyc >= 1 && act_cyc <= 3));
    bus.sqr_out   = real_d ? root(bus.sqr_in1) : 32'hDEADBEEF;
    bus.sqr_flags = real_d ? flag_v : 5'b11110;
  end
  task automatic set_req(input int i, input logic [31:0] x, input logic [2:0] m);
    bus.req_data[W*i +: W] = x;
    bus.req_round[3*i +: 3] = m;
  endtask
  task automatic observe(output logic [3:0] og, output int ogc, output int olat, output int oacts,
                         output int oextra, output logic [1:0] oid, output logic [31:0] od,
                         output logic [4:0] of, output logic [31:0] oin1, output logic [2:0] orm,
                         output bit ochg, output bit oto);
    int n;
    bit first;
    og = '0; ogc = 0; olat = 0; oacts = 0; oextra = 0; oid = '0; od = '0; of = '0;
    oin1 = '0; orm = '0; ochg = 1'b0; oto = 1'b0; first = 1'b1; n = 0;
    #1;
    while (bus.req_ready == '0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (bus.req_ready == '0) begin
      oto = 1'b1;
      return;
    end
    og = bus.req_ready;
    ogc = cyc;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (bus.req_ready != '0) oextra++;
      if (bus.sqr_act) begin
        oacts++;
        if (first) begin
          oin1 = bus.sqr_in1;
          orm = bus.sqr_round_m;
          first = 1'b0;
        end else if (bus.sqr_in1 !== oin1 || bus.sqr_round_m !== orm) ochg = 1'b1;
      end
    end while (!bus.rsp_valid && n < 200);
    oto = !bus.rsp_valid;
    olat = n;
    oid = bus.rsp_id;
    od = bus.rsp_data;
    of = bus.rsp_flags;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 4'b1111;
    bus.req_data = '0;
    bus.req_round = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (bus.req_ready !== 4'b0) begin bad++; $display("FAIL reset_req_ready got=%b want=0000", bus.req_ready); end
    total++;
    if ({bus.busy, bus.sqr_act, bus.rsp_valid} !== 3'b000) begin
      bad++; $display("FAIL reset_ctrl got busy/act/valid=%b want=000", {bus.busy, bus.sqr_act, bus.rsp_valid});
    end
    total++;
    if ({bus.rsp_data, bus.rsp_flags, bus.rsp_id, bus.sqr_in1} !== '0) begin
      bad++; $display("FAIL reset_data got data=%h flags=%b id=%0d in1=%h want all 0", bus.rsp_data, bus.rsp_flags, bus.rsp_id, bus.sqr_in1);
    end
    bus.req_valid = 4'b0;
    rst = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_single();
    set_req(0, 32'h40800000, 3'b000);
    bus.req_valid = 4'b0001;
    bus.rsp_ready = 1'b1;
    observe(g, gc, lat, acts, extra, id, d, f, in1, rm, chg, to);
    bus.req_valid = 4'b0;
    total++;
    if (to) begin bad++; $display("FAIL single_bound got=timeout want=response"); end
    total++;
    if (g !== 4'b0001 || extra !== 0) begin bad++; $display("FAIL single_grant got=%b extra=%0d want=0001 extra=0", g, extra); end
    total++;
    if (id !== 2'd0 || d !== 32'h40000000 || f !== 5'b0) begin
      bad++; $display("FAIL single_rsp got id=%0d data=%h flags=%b want id=0 data=40000000 flags=00000", id, d, f);
    end
    total++;
    if (lat !== 7 || acts !== 6) begin bad++; $display("FAIL single_timing got lat=%0d act=%0d want lat=7 act=6", lat, acts); end
    total++;
    if (in1 !== 32'h40800000 || rm !== 3'b000 || chg) begin
      bad++; $display("FAIL single_operand got in1=%h rm=%b chg=%0d want 40800000 000 0", in1, rm, chg);
    end
    repeat (5) @(negedge clk);
    total++;
    if (bus.busy !== 1'b0 || bus.req_ready !== 4'b0) begin
      bad++; $display("FAIL single_idle got busy=%b ready=%b want 0 0000", bus.busy, bus.req_ready);
    end
  endtask
  task automatic test_round_robin();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, ops[i], 3'(i));
    flag_v = 5'b00001;
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 1'b1;
    gc_prev = 0;
    for (int k = 0; k < 5; k++) begin
      observe(g, gc, lat, acts, extra, id, d, f, in1, rm, chg, to);
      total++;
      if (to || g !== 4'(1 << (k % 4)) || id !== 2'(k % 4)) begin
        bad++; $display("FAIL rr_grant_%0d got grant=%b id=%0d to=%0d want grant=%b id=%0d", k, g, id, to, 4'(1 << (k % 4)), k % 4);
      end
      total++;
      if (d !== rts[k % 4] || f !== 5'b0 || rm !== 3'(k % 4)) begin
        bad++; $display("FAIL rr_rsp_%0d got data=%h flags=%b rm=%b want data=%h flags=00000 rm=%b", k, d, f, rm, rts[k % 4], 3'(k % 4));
      end
      if (k > 0) begin
        total++;
        if (gc - gc_prev !== 8) begin bad++; $display("FAIL rr_spacing_%0d got=%0d want=8", k, gc - gc_prev); end
      end
      gc_prev = gc;
    end
    bus.req_valid = 4'b0;
    flag_v = 5'b0;
    @(negedge clk);
  endtask
  task automatic test_stale_done();
    stale = 1'b1;
    done_at = 7;
    set_req(2, 32'h41100000, 3'b001);
    bus.req_valid = 4'b0100;
    observe(g, gc, lat, acts, extra, id, d, f, in1, rm, chg, to);
    bus.req_valid = 4'b0;
    stale = 1'b0;
    done_at = 5;
    total++;
    if (to || g !== 4'b0100 || id !== 2'd2) begin bad++; $display("FAIL stale_grant got grant=%b id=%0d to=%0d want 0100 2", g, id, to); end
    total++;
    if (d !== 32'h40400000 || f !== 5'b0) begin bad++; $display("FAIL stale_rsp got data=%h flags=%b want 40400000 00000", d, f); end
    total++;
    if (lat !== 9 || acts !== 8) begin bad++; $display("FAIL stale_timing got lat=%0d act=%0d want lat=9 act=8", lat, acts); end
    @(negedge clk);
  endtask
  task automatic test_timeout();
    never = 1'b1;
    set_req(1, 32'h40800000, 3'b010);
    bus.req_valid = 4'b0010;
    observe(g, gc, lat, acts, extra, id, d, f, in1, rm, chg, to);
    bus.req_valid = 4'b0;
    never = 1'b0;
    total++;
    if (to || g !== 4'b0010 || id !== 2'd1) begin bad++; $display("FAIL tmo_grant got grant=%b id=%0d to=%0d want 0010 1", g, id, to); end
    total++;
    if (acts - 1 !== TIMEOUT || lat !== TIMEOUT + 2) begin
      bad++; $display("FAIL tmo_cycles got wait=%0d lat=%0d want wait=%0d lat=%0d", acts - 1, lat, TIMEOUT, TIMEOUT + 2);
    end
    total++;
    if (d !== 32'h7FC00000 || f !== 5'b10001) begin bad++; $display("FAIL tmo_rsp got data=%h flags=%b want 7fc00000 10001", d, f); end
    total++;
    if (rm !== 3'b010 || in1 !== 32'h40800000 || chg) begin
      bad++; $display("FAIL tmo_operand got in1=%h rm=%b chg=%0d want 40800000 010 0", in1, rm, chg);
    end
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      bad++; $display("FAIL tmo_idle got busy=%b valid=%b want 0 0", bus.busy, bus.rsp_valid);
    end
  endtask
  task automatic test_backpressure();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    done_at = 4;
    set_req(0, 32'h40800000, 3'b000);
    set_req(3, 32'h41800000, 3'b100);
    bus.req_valid = 4'b1001;
    bus.rsp_ready = 1'b0;
    observe(g, gc, lat, acts, extra, id, d, f, in1, rm, chg, to);
    total++;
    if (to || g !== 4'b0001 || lat !== 6) begin bad++; $display("FAIL bp_first got grant=%b lat=%0d to=%0d want 0001 6", g, lat, to); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h40000000 || bus.req_ready !== 4'b0) begin
        bad++; $display("FAIL bp_hold_%0d got valid=%b data=%h ready=%b want 1 40000000 0000", i, bus.rsp_valid, bus.rsp_data, bus.req_ready);
      end
    end
    bus.rsp_ready = 1'b1;
    c0 = cyc;
    observe(g, gc, lat, acts, extra, id, d, f, in1, rm, chg, to);
    total++;
    if (to || g !== 4'b1000 || gc !== c0 + 1) begin
      bad++; $display("FAIL bp_regrant got grant=%b at=%0d to=%0d want 1000 at=%0d", g, gc, to, c0 + 1);
    end
    total++;
    if (id !== 2'd3 || d !== 32'h40800000 || lat !== 6) begin
      bad++; $display("FAIL bp_second got id=%0d data=%h lat=%0d want 3 40800000 6", id, d, lat);
    end
    gc_prev = gc;
    observe(g, gc, lat, acts, extra, id, d, f, in1, rm, chg, to);
    total++;
    if (to || g !== 4'b0001 || gc - gc_prev !== 7) begin
      bad++; $display("FAIL bp_min_spacing got grant=%b spacing=%0d to=%0d want 0001 7", g, gc - gc_prev, to);
    end
    bus.req_valid = 4'b0;
    done_at = 5;
    @(negedge clk);
  endtask
  task automatic test_reset_mid_wait();
    int n;
    never = 1'b1;
    set_req(0, 32'h3F800000, 3'b000);
    set_req(2, 32'h41100000, 3'b000);
    bus.req_valid = 4'b0101;
    bus.rsp_ready = 1'b1;
    n = 0;
    #1;
    while (bus.req_ready == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (bus.req_ready !== 4'b0100) begin bad++; $display("FAIL rstw_grant got=%b want=0100", bus.req_ready); end
    repeat (4) @(negedge clk);
    total++;
    if (bus.sqr_act !== 1'b1) begin bad++; $display("FAIL rstw_in_wait got act=%b want 1", bus.sqr_act); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    never = 1'b0;
    #1;
    total++;
    if ({bus.busy, bus.sqr_act, bus.rsp_valid} !== 3'b000) begin
      bad++; $display("FAIL rstw_idle got busy/act/valid=%b want 000", {bus.busy, bus.sqr_act, bus.rsp_valid});
    end
    total++;
    if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL rstw_next_grant got=%b want=0001", bus.req_ready); end
    observe(g, gc, lat, acts, extra, id, d, f, in1, rm, chg, to);
    bus.req_valid = 4'b0;
    total++;
    if (to || id !== 2'd0 || d !== 32'h3F800000 || lat !== 7) begin
      bad++; $display("FAIL rstw_rsp got id=%0d data=%h lat=%0d to=%0d want 0 3f800000 7", id, d, lat, to);
    end
    @(negedge clk);
  endtask
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_stale_done();
    test_timeout();
    test_backpressure();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
